// File: rtl/snn_run_sequencer_pkg.sv
// Shared SNN sequencer definitions: FSM state encoding, default label width
// and the value of the serial label start bit.
package snn_run_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } seq_state_e;

  localparam int   LABEL_W_DEF   = 4;
  localparam logic LBL_START_BIT = 1'b1;

endpackage

// File: rtl/snn_label_rx.sv
// Serial label deserializer.
// A frame is one start bit followed by LABEL_W data bits, MSB first, one bit
// per cycle. valid_o pulses for one cycle after the last data bit; label_o
// holds the most recent complete frame.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   enable_i      receiver active; low aborts any partial frame
//   bit_i         serial label line
//   valid_o       one-cycle frame-complete strobe
//   label_o       received label
module snn_label_rx
  import snn_run_sequencer_pkg::*;
#(
  parameter int LABEL_W = LABEL_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable_i,
  input  logic               bit_i,
  output logic               valid_o,
  output logic [LABEL_W-1:0] label_o
);

  localparam int BC_W = $clog2(LABEL_W + 1);

  logic [BC_W-1:0]    cnt_q, cnt_d;     // data bits still to receive
  logic [LABEL_W-1:0] sh_q, sh_d;
  logic [LABEL_W-1:0] label_q, label_d;
  logic               valid_q, valid_d;
  logic [LABEL_W:0]   sh_ext;

  assign sh_ext = {sh_q, bit_i};

  always_comb begin
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    label_d = label_q;
    valid_d = 1'b0;
    if (!enable_i) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (cnt_q == '0) begin
      if (bit_i == LBL_START_BIT) cnt_d = BC_W'(LABEL_W);
    end else begin
      sh_d  = sh_ext[LABEL_W-1:0];
      cnt_d = cnt_q - BC_W'(1);
      if (cnt_q == BC_W'(1)) begin
        valid_d = 1'b1;
        label_d = sh_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      sh_q    <= '0;
      label_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      label_q <= label_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign label_o = label_q;

endmodule

// File: rtl/snn_run_sequencer.sv
// SNN run sequencer: accepts a run command, starts the core, forwards
// BEATS_PER_SAMPLE beats per sample from the host to the core with no
// storage, and in inference mode collects one serial label per sample.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   cmd_valid_i/cmd_ready_o      run request handshake (ready == idle)
//   cmd_train_i, cmd_num_i       run type (1 = training) and sample count
//   src_valid_i/src_data_i/src_ready_o   host beat stream
//   snn_valid_o/snn_data_o/snn_ready_i   core beat stream (combinational)
//   snn_start_training_o/snn_start_inference_o  one-cycle start pulses
//   snn_start_ready_i            core can start
//   snn_label_bit_i              serial label line from the core
//   res_valid_o/res_label_o/res_index_o  label strobe, label, sample index
//   done_o                       run-complete pulse
//   error_o                      drain timeout, sticky until next command
module snn_run_sequencer
  import snn_run_sequencer_pkg::*;
#(
  parameter int DATA_W           = 66,
  parameter int BEATS_PER_SAMPLE = 15,
  parameter int LABEL_W          = LABEL_W_DEF,
  parameter int CNT_W            = 16,
  parameter int TIMEOUT          = 65535
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_train_i,
  input  logic [CNT_W-1:0]   cmd_num_i,
  input  logic               src_valid_i,
  input  logic [DATA_W-1:0]  src_data_i,
  output logic               src_ready_o,
  output logic               snn_valid_o,
  output logic [DATA_W-1:0]  snn_data_o,
  input  logic               snn_ready_i,
  output logic               snn_start_training_o,
  output logic               snn_start_inference_o,
  input  logic               snn_start_ready_i,
  input  logic               snn_label_bit_i,
  output logic               res_valid_o,
  output logic [LABEL_W-1:0] res_label_o,
  output logic [CNT_W-1:0]   res_index_o,
  output logic               done_o,
  output logic               error_o
);

  localparam int BEAT_W = (BEATS_PER_SAMPLE > 1) ? $clog2(BEATS_PER_SAMPLE) : 1;
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  seq_state_e         state_q, state_d;
  logic               train_q, train_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]   samp_q, samp_d;
  logic [CNT_W-1:0]   lbl_cnt_q, lbl_cnt_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [LABEL_W-1:0] res_label_q, res_label_d;

  logic               xfer, last_beat, last_samp;
  logic               rx_en, rx_valid, strobe, drain_fin, timeout_hit;
  logic [LABEL_W-1:0] rx_label;

  assign xfer      = (state_q == ST_STREAM) && src_valid_i && snn_ready_i;
  assign last_beat = (beat_q == BEAT_W'(BEATS_PER_SAMPLE - 1));
  assign last_samp = (samp_q == num_q - CNT_W'(1));

  // Labels are only meaningful while an inference run is streaming/draining.
  assign rx_en  = !train_q && ((state_q == ST_STREAM) || (state_q == ST_DRAIN));
  // Frames beyond the requested sample count are dropped.
  assign strobe = rx_valid && rx_en && (lbl_cnt_q < num_q);

  // Drain finishes in the same cycle as the last label strobe.
  assign drain_fin = (state_q == ST_DRAIN) &&
                     ((strobe && (lbl_cnt_q == num_q - CNT_W'(1))) || (lbl_cnt_q == num_q));
  // Registered done/error land TIMEOUT cycles after drain entry.
  assign timeout_hit = (state_q == ST_DRAIN) && !drain_fin && !strobe &&
                       (to_q == TO_W'(TIMEOUT - 1));

  snn_label_rx #(.LABEL_W(LABEL_W)) u_rx (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable_i (rx_en),
    .bit_i    (snn_label_bit_i),
    .valid_o  (rx_valid),
    .label_o  (rx_label)
  );

  always_comb begin
    state_d               = state_q;
    train_d               = train_q;
    num_d                 = num_q;
    beat_d                = beat_q;
    samp_d                = samp_q;
    lbl_cnt_d             = lbl_cnt_q;
    to_d                  = to_q;
    done_d                = 1'b0;
    err_d                 = err_q;
    res_label_d           = res_label_q;
    snn_start_training_o  = 1'b0;
    snn_start_inference_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          train_d   = cmd_train_i;
          num_d     = cmd_num_i;
          beat_d    = '0;
          samp_d    = '0;
          lbl_cnt_d = '0;
          to_d      = '0;
          err_d     = 1'b0;
          if (cmd_num_i == '0) done_d  = 1'b1;
          else                 state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (snn_start_ready_i) begin
          snn_start_training_o  = train_q;
          snn_start_inference_o = !train_q;
          state_d               = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          if (last_beat) begin
            beat_d = '0;
            samp_d = samp_q + CNT_W'(1);
            if (last_samp) begin
              if (train_q) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end else begin
                state_d = ST_DRAIN;
              end
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        to_d = to_q + TO_W'(1);
        if (drain_fin) begin
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (strobe) begin
      lbl_cnt_d   = lbl_cnt_q + CNT_W'(1);
      res_label_d = rx_label;
      to_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      train_q     <= 1'b0;
      num_q       <= '0;
      beat_q      <= '0;
      samp_q      <= '0;
      lbl_cnt_q   <= '0;
      to_q        <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      res_label_q <= '0;
    end else begin
      state_q     <= state_d;
      train_q     <= train_d;
      num_q       <= num_d;
      beat_q      <= beat_d;
      samp_q      <= samp_d;
      lbl_cnt_q   <= lbl_cnt_d;
      to_q        <= to_d;
      done_q      <= done_d;
      err_q       <= err_d;
      res_label_q <= res_label_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign src_ready_o = (state_q == ST_STREAM) && snn_ready_i;
  assign snn_valid_o = xfer;
  assign snn_data_o  = src_data_i;
  assign res_valid_o = strobe;
  assign res_label_o = strobe ? rx_label : res_label_q;
  assign res_index_o = lbl_cnt_q;
  assign done_o      = done_q || drain_fin;
  assign error_o     = err_q;

endmodule
